// File: rtl/count_seq_checker_if.sv
// Beat and status bundle between a counter stream source and the sequence checker.
// The master side drives beats and observes status. The slave side (the checker)
// consumes beats and drives status.
interface count_seq_checker_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             busy;
    logic             done;
    logic             error;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] match_count;
    logic [WIDTH-1:0] err_data;
    logic [7:0]       err_count;

    modport master (
        output in_valid, in_data,
        input  busy, done, error, expected, match_count, err_data, err_count
    );

    modport slave (
        input  in_valid, in_data,
        output busy, done, error, expected, match_count, err_data, err_count
    );
endinterface

// File: rtl/count_seq_checker.sv
// Receive-side checker for an up-counter stream running START..STOP.
// The checker locks onto START and then expects +1 per beat. It flags mismatches
// (sticky) and reports completion once STOP arrives in order.
// All outputs are registered and appear one cycle after the deciding beat.
module count_seq_checker #(
    parameter int WIDTH = 8,
    parameter int START = 5,
    parameter int STOP  = 67
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  restart,
    count_seq_checker_if.slave    bus
);
    localparam logic [WIDTH-1:0] L_START    = WIDTH'(START);
    localparam logic [WIDTH-1:0] L_STOP     = WIDTH'(STOP);
    localparam logic [WIDTH-1:0] L_START_P1 = WIDTH'(START + 1);
    localparam logic             L_ONE_BEAT = (START == STOP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t           r_state,       w_state_nxt;
    logic             r_done,        w_done_nxt;
    logic             r_error,       w_error_nxt;
    logic [WIDTH-1:0] r_expected,    w_expected_nxt;
    logic [WIDTH-1:0] r_match_count, w_match_count_nxt;
    logic [WIDTH-1:0] r_err_data,    w_err_data_nxt;
    logic [7:0]       r_err_count,   w_err_count_nxt;

    // Error counter sticks at its maximum instead of wrapping back to zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Next-state and next-output decision: restart wins over a beat on the same edge.
    always_comb begin
        w_state_nxt       = r_state;
        w_done_nxt        = r_done;
        w_error_nxt       = r_error;
        w_expected_nxt    = r_expected;
        w_match_count_nxt = r_match_count;
        w_err_data_nxt    = r_err_data;
        w_err_count_nxt   = r_err_count;

        if (restart) begin
            w_state_nxt       = S_IDLE;
            w_done_nxt        = 1'b0;
            w_error_nxt       = 1'b0;
            w_expected_nxt    = '0;
            w_match_count_nxt = '0;
        end else if (bus.in_valid) begin
            case (r_state)
                // Hunting for START. A stray beat before START is not an error.
                // A resync after a mismatch keeps the error flag set.
                S_IDLE, S_ERROR: begin
                    if (bus.in_data == L_START) begin
                        w_match_count_nxt = WIDTH'(1);
                        if (L_ONE_BEAT) begin
                            w_state_nxt    = S_DONE;
                            w_done_nxt     = 1'b1;
                            w_expected_nxt = L_STOP;
                        end else begin
                            w_state_nxt    = S_TRACK;
                            w_expected_nxt = L_START_P1;
                        end
                    end
                end
                S_TRACK: begin
                    if (bus.in_data == r_expected) begin
                        w_match_count_nxt = r_match_count + WIDTH'(1);
                        if (bus.in_data == L_STOP) begin
                            // STOP is terminal, so expected holds rather than wrapping.
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_expected_nxt = r_expected + WIDTH'(1);
                        end
                    end else begin
                        w_state_nxt     = S_ERROR;
                        w_error_nxt     = 1'b1;
                        w_err_data_nxt  = bus.in_data;
                        w_err_count_nxt = sat_inc8(r_err_count);
                    end
                end
                default: ; // S_DONE: every beat is ignored until restart or reset
            endcase
        end
    end

    // Register the state and all outputs. Reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_expected    <= '0;
            r_match_count <= '0;
            r_err_data    <= '0;
            r_err_count   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_done        <= w_done_nxt;
            r_error       <= w_error_nxt;
            r_expected    <= w_expected_nxt;
            r_match_count <= w_match_count_nxt;
            r_err_data    <= w_err_data_nxt;
            r_err_count   <= w_err_count_nxt;
        end
    end

    assign bus.busy        = (r_state == S_TRACK);
    assign bus.done        = r_done;
    assign bus.error       = r_error;
    assign bus.expected    = r_expected;
    assign bus.match_count = r_match_count;
    assign bus.err_data    = r_err_data;
    assign bus.err_count   = r_err_count;
endmodule
